ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_AMOUNT, default 16: number of words read per burst (range 1..DEPTH).
REQ-002 SHALL have parameter DEPTH, default 16: memory depth; localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ram_available, input, 1: memory-filled flag from the RAM write side (level).
REQ-006 SHALL have port addrb, output, ADDR_WIDTH: RAM read address, registered.
REQ-007 SHALL have port doutb, input, int (32): RAM read data, combinational in addrb.
REQ-008 SHALL have port m_data, output, int (32): stream data, registered.
REQ-009 SHALL have port m_valid, output, 1: stream valid.
REQ-010 SHALL have port m_ready, input, 1: stream ready from consumer.
REQ-011 SHALL have port m_last, output, 1: marks final word of a burst; qualified by m_valid.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the last word is accepted.
REQ-014 SHALL have port checksum, output, 32: burst checksum; see Configuration.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-016 SHALL detect a trigger as a rising edge of ram_available (registered previous value 0, current 1).
REQ-017 IDLE: addrb held 0; on trigger SHALL go to STREAM next cycle.
REQ-018 Load condition SHALL be (!m_valid || m_ready) while in STREAM.
REQ-019 On load: m_data<=doutb, m_valid<=1, m_last<=(addrb==DATA_AMOUNT-1), addrb<=addrb+1.
REQ-020 STREAM with load at addrb==DATA_AMOUNT-1 SHALL go to DRAIN; addrb SHALL wrap to 0.
REQ-021 DRAIN: on m_valid&&m_ready SHALL clear m_valid and m_last, pulse done, go to IDLE.
REQ-022 While m_valid && !m_ready, m_data, m_last, m_valid SHALL hold stable (no load, no addrb change).
REQ-023 In STREAM, if m_valid && !m_ready, SHALL perform no load; m_valid SHALL drop only in DRAIN.
REQ-024 Latency: trigger seen at edge N -> STREAM after N -> first m_valid after edge N+1; full throughput 1 word/cycle with m_ready=1.
REQ-025 Triggers in STREAM or DRAIN SHALL be ignored; ram_available held high SHALL NOT retrigger.
REQ-026 DATA_AMOUNT==1: single load with m_last=1, then DRAIN.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, addrb=0, m_data=0, m_valid=0, m_last=0, done=0, checksum=0, edge register=0.
REQ-028 Reset mid-burst SHALL abandon the burst; after release, a new rising edge is required to start.

Configuration
REQ-029 Macro READER_CHECKSUM_EN: when defined, checksum SHALL accumulate m_data of every handshaken beat, modulo 2^32, cleared on IDLE->STREAM, final value valid from the done cycle until next burst start.
REQ-030 When READER_CHECKSUM_EN is undefined, checksum SHALL be constant 0 and no accumulator logic SHALL be built.

Verification
REQ-031 RAM words 0..15 = 1..16, m_ready=1, ram_available 0->1 -> m_data 1..16 on 16 consecutive cycles, m_last on 16, done one cycle after, checksum=136 (macro on) / 0 (off).
REQ-032 Same data, m_ready toggling 1,0,1,0 -> 16 beats in order, no duplicates or drops, data stable while stalled.
REQ-033 ram_available held high 40 cycles after burst -> exactly one burst, busy low after done.
REQ-034 rst_n asserted after 5th beat -> outputs zero immediately; re-trigger -> full burst restarting at address 0 with m_data=1.
REQ-035 Second ram_available rising edge during STREAM -> ignored, single burst of 16 beats.
REQ-036 DATA_AMOUNT=1, word 0 = 0xDEADBEEF -> one beat with m_last=1, done pulse, checksum=0xDEADBEEF (macro on).

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: on a rising edge of ram_available, reads DATA_AMOUNT words
// from a RAM with a combinational read port and emits them as a valid/ready stream.
// Each word is fetched only when the output register is empty or being consumed,
// so the stream runs at one word per cycle while m_ready stays high.
// Optional feature: define READER_CHECKSUM_EN to build a modulo-2^32 sum of
// every handshaken beat. Without it, checksum is tied to zero.
module ram_stream_reader #(
    parameter  int DATA_AMOUNT = 16,
    parameter  int DEPTH       = 16,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ram_available,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb,
    output logic [31:0]           m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_AMOUNT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ram_avail_q;
    logic [ADDR_WIDTH-1:0] r_addrb;
    logic [31:0]           r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_done;

    logic w_trigger;
    logic w_accept;
    logic w_at_last;
    logic w_load;
    logic w_start;
    logic w_drain_accept;

    // A level that was low last cycle and is high now starts a burst; a held level does not.
    assign w_trigger = ram_available && !r_ram_avail_q;
    assign w_accept  = r_m_valid && m_ready;
    assign w_at_last = (r_addrb == LAST_ADDR);

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: leave STREAM after the last word is loaded, leave DRAIN once it is taken.
    // NOTE: the default assignment at the top keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_trigger)            w_next_state = STREAM;
            STREAM:  if (w_load && w_at_last)  w_next_state = DRAIN;
            DRAIN:   if (w_accept)             w_next_state = IDLE;
            default:                           w_next_state = IDLE;
        endcase
    end

    // State-derived controls: busy flag, load strobe, burst start and final handshake.
    always_comb begin
        busy           = (r_state != IDLE);
        w_load         = (r_state == STREAM) && (!r_m_valid || m_ready);
        w_start        = (r_state == IDLE) && w_trigger;
        w_drain_accept = (r_state == DRAIN) && w_accept;
    end

    // Datapath: edge-detect register, read address, output register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_avail_q <= 1'b0;
            r_addrb       <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_ram_avail_q <= ram_available;
            r_done        <= w_drain_accept;
            if (w_load) begin
                r_m_data  <= doutb;
                r_m_valid <= 1'b1;
                r_m_last  <= w_at_last;
                r_addrb   <= w_at_last ? '0 : r_addrb + ADDR_WIDTH'(1);
            end else if (w_drain_accept) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end else if (r_state == IDLE) begin
                r_addrb   <= '0;
            end
        end
    end

`ifdef READER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of accepted beats, restarted when a new burst begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + r_m_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign addrb   = r_addrb;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign done    = r_done;

endmodule
